// File: rtl/filtro_biquad_multicanal.sv
// Multichannel biquad IIR filter with one time-shared multiplier-accumulator.
// Per channel: y = b0*u + b1*u1 + b2*u2 + a1*y1 + a2*y2. The feedback
// coefficients are stored already negated, so every term is added.
// Each channel takes five MAC cycles and one write-back cycle.
module filtro_biquad_multicanal #(
  parameter int N   = 25,
  parameter int F   = 20,
  parameter int NCH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Bandera_ADC,
  input  logic [NCH*N-1:0] Uk,
  input  logic             Limpiar,
  input  logic             Coef_We,
  input  logic [2:0]       Coef_Addr,
  input  logic [N-1:0]     Coef_Data,
  output logic [NCH*N-1:0] Yk,
  output logic             Bandera_Listo,
  output logic             Ocupado,
  output logic             Saturacion,
  output logic             Sobrecarga
);

  localparam int AW = 2*N + 3;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
  localparam logic signed [N-1:0]  COEF_ONE = {{(N-F-1){1'b0}}, 1'b1, {F{1'b0}}};
  localparam logic signed [AW-1:0] MAX_W = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_W = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ESCRIBE} state_t;

  state_t state, state_nx;
  logic [2:0]      tap;
  logic [CW-1:0]   chan;
  logic signed [N-1:0]  coef  [5];
  logic signed [N-1:0]  u_cap [NCH];
  logic signed [N-1:0]  u1    [NCH];
  logic signed [N-1:0]  u2    [NCH];
  logic signed [N-1:0]  y1    [NCH];
  logic signed [N-1:0]  y2    [NCH];
  logic signed [N-1:0]  hold  [NCH];
  logic signed [AW-1:0] acc;
  logic [NCH*N-1:0]     yk_r;
  logic                 sat_any;
  logic                 listo_r;
  logic                 sat_r;
  logic                 sobre_r;

  logic signed [N-1:0]   cf;
  logic signed [N-1:0]   oper;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  acc_nx;
  logic signed [AW-1:0]  rnd;
  logic signed [N-1:0]   y_sat;
  logic                  sat_now;

  // Round half up: add half an LSB of the result, then shift arithmetically.
  function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] half;
    half = '0;
    half[F-1] = 1'b1;
    return (a + half) >>> F;
  endfunction

  // Clamp the rounded value to the representable N-bit range.
  function automatic logic signed [N-1:0] clamp(input logic signed [AW-1:0] r);
    if (r > MAX_W)      return MAX_W[N-1:0];
    else if (r < MIN_W) return MIN_W[N-1:0];
    else                return r[N-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [AW-1:0] r);
    return (r > MAX_W) || (r < MIN_W);
  endfunction

  // Select the coefficient/operand pair for the current tap and form the product.
  always_comb begin
    cf   = '0;
    oper = '0;
    case (tap)
      3'd0: begin cf = coef[0]; oper = u_cap[chan]; end
      3'd1: begin cf = coef[1]; oper = u1[chan];    end
      3'd2: begin cf = coef[2]; oper = u2[chan];    end
      3'd3: begin cf = coef[3]; oper = y1[chan];    end
      3'd4: begin cf = coef[4]; oper = y2[chan];    end
      default: begin cf = '0; oper = '0; end
    endcase
    prod    = (2*N)'(cf) * (2*N)'(oper);
    acc_nx  = acc + AW'(prod);
    rnd     = round_shift(acc);
    y_sat   = clamp(rnd);
    sat_now = out_of_range(rnd);
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; Limpiar aborts any set in progress.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Bandera_ADC && !Limpiar) state_nx = MAC;
      MAC:     if (Limpiar) state_nx = IDLE;
               else if (tap == 3'd4) state_nx = ESCRIBE;
      ESCRIBE: if (Limpiar) state_nx = IDLE;
               else if (chan == LAST) state_nx = IDLE;
               else state_nx = MAC;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: coefficient bank, capture, accumulate, write-back and flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tap     <= '0;
      chan    <= '0;
      acc     <= '0;
      yk_r    <= '0;
      sat_any <= 1'b0;
      listo_r <= 1'b0;
      sat_r   <= 1'b0;
      sobre_r <= 1'b0;
      coef[0] <= COEF_ONE;
      for (int i = 1; i < 5; i++) coef[i] <= '0;
      for (int c = 0; c < NCH; c++) begin
        u_cap[c] <= '0;
        u1[c]    <= '0;
        u2[c]    <= '0;
        y1[c]    <= '0;
        y2[c]    <= '0;
        hold[c]  <= '0;
      end
    end else begin
      listo_r <= 1'b0;
      sat_r   <= 1'b0;
      sobre_r <= Bandera_ADC && (state != IDLE);
      // Coefficients only change between sample sets.
      if (state == IDLE && Coef_We && Coef_Addr <= 3'd4)
        coef[Coef_Addr] <= Coef_Data;
      if (Limpiar) begin
        for (int c = 0; c < NCH; c++) begin
          u1[c] <= '0;
          u2[c] <= '0;
          y1[c] <= '0;
          y2[c] <= '0;
        end
      end else begin
        case (state)
          IDLE: if (Bandera_ADC) begin
            for (int c = 0; c < NCH; c++) u_cap[c] <= Uk[c*N +: N];
            acc     <= '0;
            chan    <= '0;
            tap     <= '0;
            sat_any <= 1'b0;
          end
          MAC: begin
            acc <= acc_nx;
            tap <= tap + 3'd1;
          end
          ESCRIBE: begin
            hold[chan] <= y_sat;
            u2[chan]   <= u1[chan];
            u1[chan]   <= u_cap[chan];
            y2[chan]   <= y1[chan];
            y1[chan]   <= y_sat;
            if (chan == LAST) begin
              for (int c = 0; c < NCH; c++) begin
                if (c == NCH - 1) yk_r[c*N +: N] <= y_sat;
                else              yk_r[c*N +: N] <= hold[c];
              end
              listo_r <= 1'b1;
              sat_r   <= sat_any | sat_now;
            end else begin
              chan    <= chan + 1'b1;
              tap     <= '0;
              acc     <= '0;
              sat_any <= sat_any | sat_now;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Yk            = yk_r;
  assign Bandera_Listo = listo_r;
  assign Saturacion    = sat_r;
  assign Sobrecarga    = sobre_r;
  assign Ocupado       = (state != IDLE);

endmodule

// File: tb/tb_filtro_biquad_multicanal.sv
// Bench for filtro_biquad_multicanal with N=16, F=14, NCH=2.
module tb_filtro_biquad_multicanal;

  localparam int N   = 16;
  localparam int F   = 14;
  localparam int NCH = 2;
  localparam longint SCALE = 64'sd1 << F;
  localparam longint HALF  = 64'sd1 << (F - 1);

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Bandera_ADC = 1'b0;
  logic [NCH*N-1:0] Uk = '0;
  logic             Limpiar = 1'b0;
  logic             Coef_We = 1'b0;
  logic [2:0]       Coef_Addr = '0;
  logic [N-1:0]     Coef_Data = '0;
  logic [NCH*N-1:0] Yk;
  logic             Bandera_Listo, Ocupado, Saturacion, Sobrecarga;

  filtro_biquad_multicanal #(.N(N), .F(F), .NCH(NCH)) dut (
    .Clk(Clk), .Reset(Reset), .Bandera_ADC(Bandera_ADC), .Uk(Uk),
    .Limpiar(Limpiar), .Coef_We(Coef_We), .Coef_Addr(Coef_Addr),
    .Coef_Data(Coef_Data), .Yk(Yk), .Bandera_Listo(Bandera_Listo),
    .Ocupado(Ocupado), .Saturacion(Saturacion), .Sobrecarga(Sobrecarga)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer arithmetic on the filter equation.
  longint mcoef [5];
  longint mu1 [NCH], mu2 [NCH], my1 [NCH], my2 [NCH];

  typedef struct {
    bit clr; bit setc;
    logic [15:0] b0, b1, a1, u0, u1, e0, e1;
    bit esat;
  } vec_t;
  vec_t tbl [11];

  logic [15:0] got0, got1;
  bit          gotsat;
  int          gotlat;
  logic [15:0] ex0, ex1;
  bit          exsat;
  int          nlisto;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    mcoef[0] = SCALE;
    for (int i = 1; i < 5; i++) mcoef[i] = 0;
    model_clear();
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      mu1[c] = 0; mu2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
  endtask

  task automatic model_step(input logic [15:0] a0, input logic [15:0] a1,
                            output logic [15:0] e0, output logic [15:0] e1, output bit es);
    longint u [NCH];
    longint acc, r;
    logic [15:0] e [NCH];
    u[0] = sx(a0);
    u[1] = sx(a1);
    es = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      acc = mcoef[0]*u[c] + mcoef[1]*mu1[c] + mcoef[2]*mu2[c] + mcoef[3]*my1[c] + mcoef[4]*my2[c];
      r = floor_div(acc + HALF, SCALE);
      if (r > 32767) begin r = 32767; es = 1'b1; end
      else if (r < -32768) begin r = -32768; es = 1'b1; end
      mu2[c] = mu1[c]; mu1[c] = u[c];
      my2[c] = my1[c]; my1[c] = r;
      e[c] = 16'(r);
    end
    e0 = e[0];
    e1 = e[1];
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic coef_write(input logic [2:0] a, input logic [15:0] d);
    Coef_We = 1'b1; Coef_Addr = a; Coef_Data = d;
    tick();
    Coef_We = 1'b0;
    mcoef[a] = sx(d);
  endtask

  task automatic clear_hist();
    Limpiar = 1'b1;
    tick();
    Limpiar = 1'b0;
    model_clear();
  endtask

  // Strobe one sample set and wait (bounded) for the completion pulse.
  task automatic run_sample(input logic [15:0] a0, input logic [15:0] a1,
                            output logic [15:0] y0, output logic [15:0] yy1,
                            output bit s, output int lat);
    Uk = {a1, a0};
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    Coef_We = 1'b0;
    lat = 0;
    while (!Bandera_Listo && lat < 40) begin
      tick();
      lat++;
    end
    y0 = Yk[15:0];
    yy1 = Yk[31:16];
    s = Saturacion;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'hE000, 16'h1234, 16'hE000, 0};
    tbl[1]  = '{1, 1, 16'h2000, 16'h0000, 16'h0000, 16'h4000, 16'h0001, 16'h2000, 16'h0001, 0};
    tbl[2]  = '{1, 1, 16'h4000, 16'h0000, 16'h2000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 0};
    tbl[3]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0};
    tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 0};
    tbl[5]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 0};
    tbl[6]  = '{1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
    tbl[7]  = '{1, 1, 16'h4000, 16'h4000, 16'h0000, 16'h7000, 16'h0100, 16'h7000, 16'h0100, 0};
    tbl[8]  = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h7000, 16'h0100, 16'h7FFF, 16'h0200, 1};
    tbl[9]  = '{1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h9000, 16'hFF00, 16'h9000, 16'hFF00, 0};
    tbl[10] = '{0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h9000, 16'hFF00, 16'h8000, 16'hFE00, 1};

    model_reset();
    #23;
    Reset = 1'b0;
    tick();
    check("reset_yk", Yk, 32'h0);
    check("reset_flags", {Bandera_Listo, Ocupado, Saturacion, Sobrecarga}, 4'b0000);

    // Table of directed vectors.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].clr) clear_hist();
      if (tbl[i].setc) begin
        coef_write(3'd0, tbl[i].b0);
        coef_write(3'd1, tbl[i].b1);
        coef_write(3'd2, 16'h0000);
        coef_write(3'd3, tbl[i].a1);
        coef_write(3'd4, 16'h0000);
      end
      model_step(tbl[i].u0, tbl[i].u1, ex0, ex1, exsat);
      run_sample(tbl[i].u0, tbl[i].u1, got0, got1, gotsat, gotlat);
      check($sformatf("vec%0d_ch0", i), got0, tbl[i].e0);
      check($sformatf("vec%0d_ch1", i), got1, tbl[i].e1);
      check($sformatf("vec%0d_sat", i), gotsat, tbl[i].esat);
      check($sformatf("vec%0d_latency", i), gotlat, 12);
    end

    // Overrun plus a coefficient write attempted while busy.
    clear_hist();
    coef_write(3'd0, 16'h4000);
    coef_write(3'd1, 16'h0000);
    coef_write(3'd3, 16'h0000);
    Uk = {16'h0222, 16'h0111};
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    tick();
    tick();
    Uk = {16'h7777, 16'h6666};
    Bandera_ADC = 1'b1;
    Coef_We = 1'b1; Coef_Addr = 3'd0; Coef_Data = 16'h2000;
    tick();
    Bandera_ADC = 1'b0;
    Coef_We = 1'b0;
    check("overrun_pulse", Sobrecarga, 1'b1);
    tick();
    check("overrun_one_cycle", Sobrecarga, 1'b0);
    nlisto = 0;
    for (int k = 0; k < 20; k++) begin
      if (Bandera_Listo) begin
        nlisto++;
        got0 = Yk[15:0];
        got1 = Yk[31:16];
      end
      tick();
    end
    check("overrun_listo_count", nlisto, 1);
    check("overrun_ch0", got0, 16'h0111);
    check("overrun_ch1", got1, 16'h0222);
    model_step(16'h0111, 16'h0222, ex0, ex1, exsat);
    model_step(16'h0100, 16'h0200, ex0, ex1, exsat);
    run_sample(16'h0100, 16'h0200, got0, got1, gotsat, gotlat);
    check("protected_b0_ch0", got0, 16'h0100);
    check("protected_b0_ch1", got1, 16'h0200);

    // Limpiar while busy: abort, no completion, Yk kept.
    Uk = {16'h3000, 16'h3000};
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    tick(); tick(); tick();
    Limpiar = 1'b1;
    tick();
    Limpiar = 1'b0;
    model_clear();
    check("abort_idle", Ocupado, 1'b0);
    nlisto = 0;
    for (int k = 0; k < 15; k++) begin
      if (Bandera_Listo) nlisto++;
      tick();
    end
    check("abort_no_listo", nlisto, 0);
    check("abort_yk_kept", Yk, {16'h0200, 16'h0100});

    // Coefficient write in the same edge as the strobe takes effect at once.
    Coef_We = 1'b1; Coef_Addr = 3'd0; Coef_Data = 16'h2000;
    mcoef[0] = sx(16'h2000);
    model_step(16'h0800, 16'hF000, ex0, ex1, exsat);
    run_sample(16'h0800, 16'hF000, got0, got1, gotsat, gotlat);
    check("same_edge_coef_ch0", got0, 16'h0400);
    check("same_edge_coef_ch1", got1, 16'hF800);

    // Asynchronous reset in the middle of MAC.
    Uk = {16'h1111, 16'h2222};
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    tick();
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_yk", Yk, 32'h0);
    check("async_rst_busy", Ocupado, 1'b0);
    #1;
    Reset = 1'b0;
    model_reset();
    tick();
    model_step(16'h0ABC, 16'h8001, ex0, ex1, exsat);
    run_sample(16'h0ABC, 16'h8001, got0, got1, gotsat, gotlat);
    check("post_rst_ch0", got0, 16'h0ABC);
    check("post_rst_ch1", got1, 16'h8001);

    // Randomized sets against the reference model.
    for (int k = 0; k < 5; k++) coef_write(3'(k), 16'($urandom_range(0, 16'hFFFF)) >>> 1);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] r0, r1;
      if (k % 8 == 7) clear_hist();
      if (k == 15) begin
        coef_write(3'd0, 16'h3000);
        coef_write(3'd3, 16'h1800);
        coef_write(3'd4, 16'hF000);
      end
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      model_step(r0, r1, ex0, ex1, exsat);
      run_sample(r0, r1, got0, got1, gotsat, gotlat);
      check($sformatf("rand%0d_ch0", k), got0, ex0);
      check($sformatf("rand%0d_ch1", k), got1, ex1);
      check($sformatf("rand%0d_sat", k), gotsat, exsat);
      check($sformatf("rand%0d_latency", k), gotlat, 12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
